// File: rtl/truth_table_sweeper.sv
// Sweeps every input pattern of a small gate block in binary order, holds each
// for HOLD_CYCLES cycles and packs the sampled outputs into one result vector.
// Optional golden-result comparator: define SWEEP_CHECK_EN.
module truth_table_sweeper #(
    parameter int N_IN        = 3,
    parameter int N_OUT       = 2,
    parameter int HOLD_CYCLES = 10,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [N_OUT-1:0]            dut_out,
    output logic [N_IN-1:0]             pat_out,
    output logic                        pat_valid,
    output logic                        busy,
    output logic                        done,
    output logic [N_OUT*(2**N_IN)-1:0]  result,
    output logic                        pass,
    output logic                        mismatch,
    output logic [1:0]                  state_dbg
);

    // Handshake: start is sampled only in IDLE (abort wins if both are high);
    // busy covers the whole sweep and done pulses for one cycle after the last capture.

    localparam int RW = N_OUT * (2 ** N_IN);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [31:0]     slot_shift;
    logic [RW-1:0]   slot_mask;
    logic [RW-1:0]   slot_data;
    logic [RW-1:0]   result_cap;
    logic            last_pat;
    logic            accept_start;
    logic            capture;

    // result with the current pattern's slot replaced by the live gate outputs
    always_comb begin
        slot_shift = 32'(pat_out) * 32'(N_OUT);
        slot_mask  = RW'({N_OUT{1'b1}}) << slot_shift;
        slot_data  = RW'(dut_out) << slot_shift;
        result_cap = (result & ~slot_mask) | slot_data;
    end

    assign last_pat     = &pat_out;
    assign accept_start = (state == S_IDLE) && start && !abort;
    assign capture      = (state == S_RUN) && !abort && (hold_cnt == H_LAST);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            pat_out   <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (accept_start) begin
                        state     <= S_RUN;
                        pat_out   <= '0;
                        hold_cnt  <= '0;
                        result    <= '0;
                        pat_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        pat_out   <= '0;
                        hold_cnt  <= '0;
                        pat_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (capture) begin
                        result   <= result_cap;
                        hold_cnt <= '0;
                        if (last_pat) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            pat_valid <= 1'b0;
                            pat_out   <= '0;
                        end else begin
                            pat_out <= pat_out + N_IN'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SWEEP_CHECK_EN
    // Verdict is judged on the result including the slot captured on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass     <= 1'b0;
            mismatch <= 1'b0;
        end else if (accept_start || (state == S_RUN && abort)) begin
            pass     <= 1'b0;
            mismatch <= 1'b0;
        end else if (capture && last_pat) begin
            pass     <= (result_cap == EXPECTED);
            mismatch <= (result_cap != EXPECTED);
        end
    end
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
    assign pass     = 1'b0;
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper around the gate model {a&b, b|c}.
module tb_truth_table_sweeper;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int HOLD  = 4;
    localparam int RW    = N_OUT * (2 ** N_IN);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            model_ones = 1'b0;
    logic [N_OUT-1:0] dut_out;
    logic [N_IN-1:0] pat_out;
    logic            pat_valid, busy, done, pass, mismatch;
    logic [RW-1:0]   result;
    logic [1:0]      state_dbg;

    int total = 0;
    int bad   = 0;
    int done_cnt;

    always #5 clk = ~clk;

    assign dut_out = model_ones ? 2'b11
                   : {pat_out[2] & pat_out[1], pat_out[1] | pat_out[0]};

    truth_table_sweeper #(
        .N_IN(N_IN), .N_OUT(N_OUT), .HOLD_CYCLES(HOLD), .EXPECTED(16'hF454)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_out(dut_out), .pat_out(pat_out), .pat_valid(pat_valid),
        .busy(busy), .done(done), .result(result), .pass(pass),
        .mismatch(mismatch), .state_dbg(state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a sweep, wait (bounded) for done, check the captured vector.
    task automatic run_sweep(input string tag, input logic [15:0] exp_res);
        bit seen;
        seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_cleared"}, 32'(result), 32'h0);
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'h1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        tick();
    endtask

    initial begin
        // reset state
        #12;
        check("rst_pat_out", 32'(pat_out), 32'h0);
        check("rst_outputs", {27'h0, pat_valid, busy, done, pass, mismatch}, 32'h0);
        check("rst_result", 32'(result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: single start pulse, pattern stepping and hold timing
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 8; p++) begin
            for (int h = 0; h < HOLD; h++) begin
                check($sformatf("t1_pat_%0d_%0d", p, h), {23'h0, pat_valid, busy, done, 1'b0, 1'b0, pat_out},
                      {23'h0, 1'b1, 1'b1, 1'b0, 2'b00, 3'(p)});
                tick();
            end
        end
        check("t1_done_pulse", {28'h0, done, busy, pat_valid, 1'b0}, 32'h8);
        check("t1_pat_zero", 32'(pat_out), 32'h0);
        check("t1_result", 32'(result), 32'hF454);
`ifdef SWEEP_CHECK_EN
        check("t5_pass", {30'h0, pass, mismatch}, 32'h2);
`else
        check("t5_flags_tied", {30'h0, pass, mismatch}, 32'h0);
`endif
        tick();
        check("t1_done_one_cycle", {30'h0, done, busy}, 32'h0);
        check("t1_result_held", 32'(result), 32'hF454);

        // 2: start held high across a sweep
        start = 1'b1;
        done_cnt = 0;
        tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("t2_done_at_end", 32'(done), 32'h1);
        tick();
        check("t2_idle_after_done", {30'h0, busy, done}, 32'h0);
        check("t2_one_done", 32'(done_cnt), 32'h1);
        tick();
        check("t2_restart_in_idle", 32'(busy), 32'h1);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t2_abort_stop", {30'h0, busy, pat_valid}, 32'h0);

        // 3: abort while pattern 3 is applied
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3 * HOLD; i++) tick();
        check("t3_at_pat3", 32'(pat_out), 32'h3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_abort_idle", {27'h0, pat_valid, busy, done, pat_out[1:0]}, 32'h0);
        check("t3_partial_result", 32'(result), 32'h0014);
        check("t3_abort_flags", {30'h0, pass, mismatch}, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        check("t3_no_done", {30'h0, done, busy}, 32'h0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("t3_abort_beats_start", 32'(busy), 32'h0);

        // 4: asynchronous reset mid pattern 5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5 * HOLD + 2; i++) tick();
        check("t4_at_pat5", 32'(pat_out), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_out", {24'h0, pat_valid, busy, done, pass, mismatch, pat_out}, 32'h0);
        check("t4_async_result", 32'(result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_sweep("t4_full", 16'hF454);

        // 6: back-to-back sweeps, second with all-ones gate outputs
        model_ones = 1'b1;
        run_sweep("t6_ones", 16'hFFFF);
`ifdef SWEEP_CHECK_EN
        check("t6_mismatch", {30'h0, pass, mismatch}, 32'h1);
`endif
        model_ones = 1'b0;
        run_sweep("t6_back", 16'hF454);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly around a small combinational gate block.
- Drives every input pattern of the gate block in binary order, holding each pattern for a programmable number of cycles.
- Samples the gate block's outputs at the end of each hold window and packs them into one result vector.
- Gives on-silicon and in-simulation sweeps without a hand-written pattern list. One start/done handshake per sweep.

Parameters:
- N_IN, 3, number of gate-block inputs; sweep covers 2^N_IN patterns.
- N_OUT, 2, number of gate-block outputs captured per pattern.
- HOLD_CYCLES, 10, cycles each pattern is held (≥2); capture on last cycle.
- EXPECTED, all 0 (width N_OUT*2^N_IN), golden result; used only with SWEEP_CHECK_EN.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  synchronous stop; return to IDLE
- dut_out  in  N_OUT  outputs of gate block (driven by pat_out)
- pat_out  out  N_IN  pattern to gate block inputs; MSB = first input (a)
- pat_valid  out  1  high while pat_out is an active sweep pattern
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at sweep completion
- result  out  N_OUT*2^N_IN  captured outputs; slot p at [p*N_OUT +: N_OUT]
- pass  out  1  checker result (see Optional Feature)
- mismatch  out  1  checker result (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): state IDLE; pat_out=0, pat_valid=0, busy=0, done=0, result=0, pass=0, mismatch=0, counters 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k → RUN after edge k. At the same edge: pat_out=0, hold counter h=0, result cleared to 0. pat_valid=busy=1 from the next cycle.
- RUN: h increments each edge. When h==HOLD_CYCLES-1 at an edge, dut_out is written to slot p (the current pat_out).
  - If p < 2^N_IN-1: pat_out=p+1, h=0.
  - If p == 2^N_IN-1: go to DONE.
- Each pattern is visible for exactly HOLD_CYCLES cycles. Last capture occurs at edge k+2^N_IN*HOLD_CYCLES.
- DONE: lasts one cycle. done=1, busy=0, pat_valid=0, pat_out returns to 0. Next edge → IDLE. result holds until the next accepted start.
- start while busy or in DONE: ignored, no queuing.
- abort=1 in RUN: next edge → IDLE.
  - pat_out=0, pat_valid=busy=0, no done pulse.
  - result keeps the slots captured so far; remaining slots stay 0.
- abort in IDLE/DONE: no effect.
- abort and start both high in IDLE: abort wins, stay IDLE.
- Reset mid-sweep: immediate return to reset values. No done pulse.
- Wrap-around: pattern counter never wraps inside a sweep; exit is via DONE.

Optional Feature:
- Macro: SWEEP_CHECK_EN.
- Defined:
  - On the DONE-entry edge, result (including the final slot) is compared to EXPECTED.
  - pass=1 if equal, mismatch=1 otherwise.
  - Both hold until the next accepted start, abort or reset, which clear them to 0.
  - Aborted sweeps never set either flag.
- Undefined: no comparator logic; pass and mismatch tied 0. EXPECTED unused.

Test Plan:
All scenarios use N_IN=3, N_OUT=2, HOLD_CYCLES=4. The bench models the gate block as dut_out={a&b, b|c}, with a=pat_out[2], b=pat_out[1], c=pat_out[0].
1. Reset then single start pulse at edge k → pat_out steps 0..7, each for 4 cycles; done high for one cycle after edge k+32; result=16'hF454; busy low after done.
2. start held high throughout sweep → exactly one sweep, one done pulse. A second sweep starts only if start is still high in IDLE after DONE.
3. abort asserted while pat_out==3 → IDLE next edge, no done. result[5:0]=6'b010100 (slots 0..2); bits [15:6]=0.
4. rst_n dropped asynchronously mid-pattern 5 → all outputs 0 immediately, without waiting for a clock edge. A new start gives a full sweep with result=16'hF454.
5. SWEEP_CHECK_EN defined, EXPECTED=16'hF454 → pass=1, mismatch=0 after done. With EXPECTED=16'hF455 → pass=0, mismatch=1.
6. Back-to-back sweeps with the model changed to dut_out=2'b11 for the second sweep → result cleared at start; second result=16'hFFFF.
